// File: rtl/led_pkg.sv
// Shared encodings for the LED breathing sequencer: run modes and the
// breath FSM states.
package led_pkg;

  localparam logic [1:0] MODE_CHASE    = 2'd0;
  localparam logic [1:0] MODE_PINGPONG = 2'd1;
  localparam logic [1:0] MODE_ALL      = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_ADVANCE   = 3'd4
  } state_e;

  // Encoding 3 is reserved and behaves as chase.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_CHASE : m;
  endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Step prescaler plus PWM compare: produces the duty-step tick and the
// registered, mask-gated LED drive.
module led_pwm_core #(
  parameter int N_LED    = 8,
  parameter int PWM_W    = 8,
  parameter int STEP_DIV = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [PWM_W-1:0] duty,
  input  logic [N_LED-1:0] mask,
  output logic             tick,
  output logic [N_LED-1:0] led_out
);

  localparam int PCNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(STEP_DIV - 1);
  localparam logic [PWM_W-1:0]  DMAX      = '1;
  localparam logic [PWM_W-1:0]  WCNT_LAST = DMAX - 1'b1;

  logic [PCNT_W-1:0] pcnt;
  logic [PWM_W-1:0]  wcnt;
  logic              lit;

  assign tick = run && (pcnt == PCNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pcnt <= '0;
    else if (!run || tick) pcnt <= '0;
    else                  pcnt <= pcnt + 1'b1;
  end

  // wcnt spans DMAX slots, so full duty is the only always-on level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wcnt <= '0;
    else if (wcnt == WCNT_LAST) wcnt <= '0;
    else                        wcnt <= wcnt + 1'b1;
  end

  assign lit = (duty == DMAX) || (wcnt < duty);

  // ---- stage boundary: compare result registered to the pins ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_out <= '0;
    else     led_out <= lit ? mask : '0;
  end

endmodule

// File: rtl/led_breath_seq.sv
// Breathing LED sequencer: ramps a shared duty up, holds, ramps down, then
// advances to the next channel according to the latched mode.
module led_breath_seq #(
  parameter int N_LED      = 8,
  parameter int PWM_W      = 8,
  parameter int STEP_DIV   = 40,
  parameter int HOLD_TICKS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  output logic [N_LED-1:0]         led_out,
  output logic [$clog2(N_LED)-1:0] cur_led,
  output logic                     cycle_done
);
  import led_pkg::*;

  localparam int IDX_W  = $clog2(N_LED);
  localparam int HCNT_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HCNT_W-1:0] HLAST   = HCNT_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
  localparam logic [PWM_W-1:0]  DMAX    = '1;
  localparam logic [PWM_W-1:0]  DMAX_M1 = DMAX - 1'b1;
  localparam logic [PWM_W-1:0]  DUTY_1  = PWM_W'(1);
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(N_LED - 1);

  state_e            state, state_nxt;
  logic [PWM_W-1:0]  duty;
  logic [HCNT_W-1:0] hcnt;
  logic              dir_up;
  logic [1:0]        mode_q;
  logic              tick;
  logic              run;
  logic [N_LED-1:0]  mask;

  function automatic logic [PWM_W-1:0] sat_step(input logic [PWM_W-1:0] d, input logic up);
    if (up) return (d == DMAX) ? d : d + 1'b1;
    return (d == '0) ? d : d - 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:      state_nxt = ST_RAMP_UP;
        ST_RAMP_UP:   if (tick && duty == DMAX_M1)
                        state_nxt = (HOLD_TICKS == 0) ? ST_RAMP_DOWN : ST_HOLD;
        ST_HOLD:      if (tick && hcnt == HLAST) state_nxt = ST_RAMP_DOWN;
        ST_RAMP_DOWN: if (tick && duty == DUTY_1) state_nxt = ST_ADVANCE;
        ST_ADVANCE:   state_nxt = ST_RAMP_UP;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    run        = 1'b0;
    cycle_done = 1'b0;
    mask       = '0;
    unique case (state)
      ST_RAMP_UP, ST_HOLD, ST_RAMP_DOWN: run = 1'b1;
      ST_ADVANCE:                        cycle_done = 1'b1;
      default:                           ;
    endcase
    // Gating on en blanks the pins on the edge that also drops to IDLE.
    if (en && state != ST_IDLE) begin
      if (mode_q == MODE_ALL) mask = '1;
      else                    mask[cur_led] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty    <= '0;
      hcnt    <= '0;
      cur_led <= '0;
      dir_up  <= 1'b1;
      mode_q  <= MODE_CHASE;
    end else if (!en) begin
      duty <= '0;
      hcnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          duty   <= '0;
          hcnt   <= '0;
          mode_q <= norm_mode(mode);
          if (norm_mode(mode) == MODE_ALL) cur_led <= '0;
        end
        ST_RAMP_UP:   if (tick) duty <= sat_step(duty, 1'b1);
        ST_HOLD:      if (tick) hcnt <= (hcnt == HLAST) ? '0 : hcnt + 1'b1;
        ST_RAMP_DOWN: if (tick) duty <= sat_step(duty, 1'b0);
        ST_ADVANCE: begin
          // Step uses the mode of the breath just finished; new mode applies after.
          mode_q <= norm_mode(mode);
          if (norm_mode(mode) == MODE_ALL) begin
            cur_led <= '0;
          end else if (mode_q == MODE_PINGPONG) begin
            if (dir_up) begin
              if (cur_led == LAST) begin
                cur_led <= LAST - 1'b1;
                dir_up  <= 1'b0;
              end else begin
                cur_led <= cur_led + 1'b1;
              end
            end else begin
              if (cur_led == '0) begin
                cur_led <= IDX_W'(1);
                dir_up  <= 1'b1;
              end else begin
                cur_led <= cur_led - 1'b1;
              end
            end
          end else if (mode_q == MODE_CHASE) begin
            cur_led <= (cur_led == LAST) ? '0 : cur_led + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  led_pwm_core #(
    .N_LED   (N_LED),
    .PWM_W   (PWM_W),
    .STEP_DIV(STEP_DIV)
  ) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .duty   (duty),
    .mask   (mask),
    .tick   (tick),
    .led_out(led_out)
  );

endmodule
